// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared constants for the fetch stage and its IF/ID bundle
package if_fetch_stage_pkg;
   localparam int          INSTR_W      = 32;
   localparam logic [31:0] NOP          = 32'h0;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: control inputs, ROM port and IF/ID outputs of the fetch stage
interface if_fetch_stage_if import if_fetch_stage_pkg::*; #(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
);
   logic                stall;
   logic                redirect_valid;
   logic [31:0]         redirect_pc;
   logic [ADDR_W-1:0]   rom_addr;
   logic [INSTR_W-1:0]  rom_instr;
   logic [31:0]         pc;
   logic [31:0]         if_pc;
   logic [31:0]         if_pc4;
   logic [INSTR_W-1:0]  if_instr;
   logic                if_valid;
   logic                align_err;
   logic [CNT_W-1:0]    fetch_count;
   modport master (
      input  stall, redirect_valid, redirect_pc, rom_instr,
      output rom_addr, pc, if_pc, if_pc4, if_instr, if_valid, align_err, fetch_count
   );
   modport slave (
      output stall, redirect_valid, redirect_pc, rom_instr,
      input  rom_addr, pc, if_pc, if_pc4, if_instr, if_valid, align_err, fetch_count
   );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, ROM addressing and IF/ID pipeline register
// with redirect > stall > run priority and a saturating fetch counter.
module if_fetch_stage import if_fetch_stage_pkg::*; #(
   parameter int          ADDR_W   = 5,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          CNT_W    = 16
) (
   input logic               clk,
   input logic               rst,
   if_fetch_stage_if.master  f
);
   logic [31:0] pc_next4;
   assign pc_next4   = f.pc + 32'd4;
   assign f.rom_addr = f.pc[ADDR_W+1:2];
   always_ff @(posedge clk) begin
      if (rst) begin
         f.pc        <= RESET_PC;
         f.align_err <= 1'b0;
      end else if (f.redirect_valid) begin
         f.pc <= {f.redirect_pc[31:2], 2'b00};
         if (|f.redirect_pc[1:0]) f.align_err <= 1'b1;
      end else if (!f.stall) begin
         f.pc <= pc_next4;
      end
   end
   // a redirect squashes the word fetched this cycle but keeps the old if_pc
   always_ff @(posedge clk) begin
      if (rst) begin
         f.if_pc       <= 32'h0;
         f.if_pc4      <= 32'h0;
         f.if_instr    <= NOP;
         f.if_valid    <= 1'b0;
         f.fetch_count <= '0;
      end else if (f.redirect_valid) begin
         f.if_instr <= NOP;
         f.if_valid <= 1'b0;
      end else if (!f.stall) begin
         f.if_instr <= f.rom_instr;
         f.if_pc    <= f.pc;
         f.if_pc4   <= pc_next4;
         f.if_valid <= 1'b1;
         if (~&f.fetch_count) f.fetch_count <= f.fetch_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vectors plus a cycle-level reference model of the fetch stage
module tb_if_fetch_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic stall = 1'b0;
   logic rv = 1'b0;
   logic [31:0] rpc = 32'h0;
   logic [31:0] rom [32];
   int total = 0;
   int bad = 0;
   if_fetch_stage_if #(.ADDR_W(5), .CNT_W(16)) fi ();
   if_fetch_stage_if #(.ADDR_W(5), .CNT_W(4))  fs ();
   assign fi.stall = stall;
   assign fi.redirect_valid = rv;
   assign fi.redirect_pc = rpc;
   assign fi.rom_instr = rom[fi.rom_addr];
   assign fs.stall = stall;
   assign fs.redirect_valid = rv;
   assign fs.redirect_pc = rpc;
   assign fs.rom_instr = rom[fs.rom_addr];
   if_fetch_stage #(.ADDR_W(5), .RESET_PC(32'h0), .CNT_W(16)) dut (.clk(clk), .rst(rst), .f(fi));
   if_fetch_stage #(.ADDR_W(5), .RESET_PC(32'h0), .CNT_W(4))  dut_s (.clk(clk), .rst(rst), .f(fs));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, a, e);
      end
   endtask
   // reference model: fetch state after each edge, from the priority rules
   logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
   logic m_v, m_al;
   int m_cnt;
   bit m_known = 0;
   always @(posedge clk) begin
      if (rst) begin
         m_pc = 32'h0; m_ipc = 0; m_ipc4 = 0; m_instr = 0; m_v = 0; m_al = 0; m_cnt = 0; m_known = 1;
      end else if (rv) begin
         if (rpc % 4 != 0) m_al = 1;
         m_pc = rpc - (rpc % 4);
         m_v = 0;
         m_instr = 0;
      end else if (!stall) begin
         m_instr = rom[int'((m_pc / 4) % 32)];
         m_ipc = m_pc;
         m_ipc4 = m_pc + 4;
         m_v = 1;
         m_pc = m_pc + 4;
         m_cnt++;
      end
   end
   always @(negedge clk) begin
      if (m_known) begin
         chk("m_pc", fi.pc, m_pc);
         chk("m_rom_addr", 32'(fi.rom_addr), (m_pc / 4) % 32);
         chk("m_if_pc", fi.if_pc, m_ipc);
         chk("m_if_pc4", fi.if_pc4, m_ipc4);
         chk("m_if_instr", fi.if_instr, m_instr);
         chk("m_if_valid", 32'(fi.if_valid), 32'(m_v));
         chk("m_align_err", 32'(fi.align_err), 32'(m_al));
         chk("m_count16", 32'(fi.fetch_count), (m_cnt > 65535) ? 65535 : m_cnt);
         chk("m_count4", 32'(fs.fetch_count), (m_cnt > 15) ? 15 : m_cnt);
      end
   end
   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 + i;
      rom[0] = 32'h24010001;
      rom[1] = 32'h24020002;
      rom[2] = 32'h00411821;
      rom[31] = 32'h8c0a0008;
      repeat (2) @(negedge clk);
      chk("rst_pc", fi.pc, 32'h0);
      chk("rst_rom_addr", 32'(fi.rom_addr), 32'h0);
      chk("rst_valid", 32'(fi.if_valid), 32'h0);
      chk("rst_count", 32'(fi.fetch_count), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("e1_instr", fi.if_instr, 32'h24010001);
      chk("e1_if_pc", fi.if_pc, 32'h0);
      chk("e1_if_pc4", fi.if_pc4, 32'h4);
      chk("e1_valid", 32'(fi.if_valid), 32'h1);
      chk("e1_rom_addr", 32'(fi.rom_addr), 32'h1);
      @(negedge clk);
      chk("e2_instr", fi.if_instr, 32'h24020002);
      chk("e2_if_pc", fi.if_pc, 32'h4);
      chk("e2_if_pc4", fi.if_pc4, 32'h8);
      chk("e2_pc", fi.pc, 32'h8);
      stall = 1'b1;
      repeat (2) @(negedge clk);
      chk("st_pc", fi.pc, 32'h8);
      chk("st_rom_addr", 32'(fi.rom_addr), 32'h2);
      chk("st_instr", fi.if_instr, 32'h24020002);
      chk("st_count", 32'(fi.fetch_count), 32'h2);
      stall = 1'b0;
      @(negedge clk);
      chk("e3_instr", fi.if_instr, 32'h00411821);
      chk("e3_if_pc", fi.if_pc, 32'h8);
      chk("e3_if_pc4", fi.if_pc4, 32'hC);
      chk("e3_count", 32'(fi.fetch_count), 32'h3);
      chk("e3_rom_addr", 32'(fi.rom_addr), 32'h3);
      rv = 1'b1; rpc = 32'h7C;
      @(negedge clk);
      chk("rd_pc", fi.pc, 32'h7C);
      chk("rd_rom_addr", 32'(fi.rom_addr), 32'h1F);
      chk("rd_valid", 32'(fi.if_valid), 32'h0);
      chk("rd_instr", fi.if_instr, 32'h0);
      chk("rd_if_pc_hold", fi.if_pc, 32'h8);
      chk("rd_count", 32'(fi.fetch_count), 32'h3);
      rv = 1'b0;
      @(negedge clk);
      chk("t7c_instr", fi.if_instr, 32'h8c0a0008);
      chk("t7c_if_pc", fi.if_pc, 32'h7C);
      chk("t7c_pc", fi.pc, 32'h80);
      chk("wrap_rom_addr", 32'(fi.rom_addr), 32'h0);
      @(negedge clk);
      chk("wrap_instr", fi.if_instr, 32'h24010001);
      chk("wrap_if_pc", fi.if_pc, 32'h80);
      chk("wrap_if_pc4", fi.if_pc4, 32'h84);
      rv = 1'b1; rpc = 32'h6; stall = 1'b1;
      @(negedge clk);
      chk("mis_pc", fi.pc, 32'h4);
      chk("mis_align", 32'(fi.align_err), 32'h1);
      chk("mis_valid", 32'(fi.if_valid), 32'h0);
      rv = 1'b0; stall = 1'b0;
      @(negedge clk);
      chk("mis_next_instr", fi.if_instr, 32'h24020002);
      chk("mis_sticky", 32'(fi.align_err), 32'h1);
      chk("mis_count", 32'(fi.fetch_count), 32'h6);
      rst = 1'b1; stall = 1'b1; rv = 1'b1; rpc = 32'h40;
      @(negedge clk);
      chk("rr_pc", fi.pc, 32'h0);
      chk("rr_if_pc", fi.if_pc, 32'h0);
      chk("rr_if_pc4", fi.if_pc4, 32'h0);
      chk("rr_instr", fi.if_instr, 32'h0);
      chk("rr_valid", 32'(fi.if_valid), 32'h0);
      chk("rr_align", 32'(fi.align_err), 32'h0);
      chk("rr_count", 32'(fi.fetch_count), 32'h0);
      rst = 1'b0; stall = 1'b0; rv = 1'b0;
      repeat (20) @(negedge clk);
      chk("sat_small", 32'(fs.fetch_count), 32'hF);
      chk("run_count", 32'(fi.fetch_count), 32'd20);
      chk("run_pc", fi.pc, 32'h50);
      repeat (3) @(negedge clk);
      chk("sat_hold", 32'(fs.fetch_count), 32'hF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipeline.
- Owns the program counter and drives the word address into the instruction ROM, which returns the instruction combinationally in the same cycle.
- Captures the returned word, with its PC, into the IF/ID pipeline register consumed by decode.
- Handles decode/execute stalls, branch/jump redirects, squashes, and a saturating fetched-instruction counter for bring-up.

Parameters:
- ADDR_W, 5, ROM word-address width; rom_addr = pc[ADDR_W+1:2].
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- CNT_W, 16, width of the fetch_count counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID register contents
- redirect_valid  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  byte-address target of the redirect
- rom_addr  out  ADDR_W  word address to the instruction ROM, combinational from pc
- rom_instr  in  32  instruction word returned by the ROM in the same cycle
- pc  out  32  current fetch PC
- if_pc  out  32  PC of the instruction held in IF/ID
- if_pc4  out  32  if_pc + 4, for link/branch base
- if_instr  out  32  instruction held in IF/ID (32'h0 = nop when squashed)
- if_valid  out  1  IF/ID holds a real instruction
- align_err  out  1  sticky; set when a misaligned redirect_pc is seen
- fetch_count  out  CNT_W  number of valid instructions latched into IF/ID, saturating

Behaviour:
- Reset values (rst=1 at an edge):
  - pc=RESET_PC
  - if_pc=0, if_pc4=0, if_instr=0
  - if_valid=0, align_err=0, fetch_count=0
  - rst overrides every other input.
- rom_addr is always pc[ADDR_W+1:2]. Upper PC bits are ignored, so the ROM image aliases (wraps) every 2^(ADDR_W+2) bytes. pc itself does not wrap until 32-bit overflow.
- Latency: an instruction appears at if_instr one clock after its PC is presented on pc/rom_addr.
- Priority at each edge: rst > redirect_valid > stall > normal.
- Normal (no stall, no redirect):
  - if_instr<=rom_instr, if_pc<=pc, if_pc4<=pc+4, if_valid<=1
  - pc<=pc+4
  - fetch_count increments, saturating at all-ones.
- Stall without redirect: pc, if_pc, if_pc4, if_instr, if_valid and fetch_count all hold.
- Redirect, including during a stall:
  - pc<={redirect_pc[31:2],2'b00}
  - if_valid<=0, if_instr<=0; if_pc/if_pc4 hold
  - fetch_count unchanged.
  - The instruction being fetched that cycle is discarded.
- A redirect with redirect_pc[1:0]!=0 also sets align_err, which stays set until rst.
- Back-to-back redirects: each one reloads pc and keeps IF/ID squashed.
- The first edge after reset release captures the instruction at RESET_PC.
- No internal FSM beyond the PC/IF-ID registers. Modes RUN/STALL/SQUASH are decoded from the inputs each cycle, per the priority above.

Decomposition:
- Shared package holds:
  - the NOP word constant (32'h0)
  - the default RESET_PC
  - the instruction-width constant (32)
- No sub-module needed. The adder (pc+4) and the IF/ID register stay inline; one always block for pc and one for IF/ID plus counter is natural.

Test Plan:
- Reset then run 4 cycles with the standard test ROM (word0=32'h24010001, word1=32'h24020002, word2=32'h00411821):
  - rom_addr goes 0,1,2,3.
  - At the 1st/2nd/3rd post-reset edges if_instr=24010001/24020002/00411821, if_pc=0/4/8, if_pc4=4/8/C.
  - if_valid=1 from the 1st edge; fetch_count=3 after the 3rd edge.
- Stall high for 2 cycles at pc=8 -> pc stays 8, rom_addr stays 2, if_instr stays 24020002, fetch_count unchanged. On release, next edge gives if_instr=00411821.
- Redirect to 32'h7C while pc=0xC -> next edge: pc=0x7C, rom_addr=5'h1F, if_valid=0, if_instr=0. Following edge: if_instr=32'h8c0a0008, if_pc=0x7C.
- Run from 0x7C unstalled -> pc=0x80, rom_addr wraps to 0, and if_instr=24010001 with if_pc=0x80.
- Redirect to 32'h0000_0006 together with stall=1 -> pc=0x4, align_err=1, if_valid=0. align_err stays 1 until rst.
- Assert rst mid-run with stall=1 and redirect_valid=1 -> all outputs return to reset values and pc=RESET_PC. Force fetch_count to all-ones and run -> it stays at 16'hFFFF.
